cc_line_serializer: RTL and testbench

CC_LINE_SERIALIZER -- requirements
Module: cc_line_serializer

---
 rtl/cc_pkg.sv | 22 ++
 rtl/cc_line_serializer_if.sv | 40 ++++
 rtl/cc_word_mux.sv | 15 +
 rtl/cc_line_serializer.sv | 134 +++++++++++++
 tb/tb_cc_line_serializer.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/cc_pkg.sv
// Shared constants, state encoding and index helper for the cache-line to AXI R serializer.
package cc_pkg;

  localparam int unsigned LINE_W   = 512;
  localparam int unsigned BEAT_W   = 64;
  localparam int unsigned BEATS    = 8;
  localparam int unsigned OFFSET_W = 3;

  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  // Critical-word-first order: the 3-bit sum wraps naturally modulo the beat count.
  function automatic logic [OFFSET_W-1:0] beat_index(input logic [OFFSET_W-1:0] offset,
                                                      input logic [OFFSET_W-1:0] cnt);
    return offset + cnt;
  endfunction

endpackage

// File: rtl/cc_line_serializer_if.sv
// Line-return and AXI R-channel bundle for cc_line_serializer.
// ID fields exist only when CC_LINE_SER_RID_EN is defined.
interface cc_line_serializer_if #(
  parameter int ID_W = 4
);
  import cc_pkg::*;

  logic                line_valid_i;
  logic                line_ready_o;
  logic [LINE_W-1:0]   line_data_i;
  logic [OFFSET_W-1:0] line_offset_i;
  logic [BEAT_W-1:0]   rdata_o;
  logic [1:0]          rresp_o;
  logic                rlast_o;
  logic                rvalid_o;
  logic                rready_i;
`ifdef CC_LINE_SER_RID_EN
  logic [ID_W-1:0]     line_id_i;
  logic [ID_W-1:0]     rid_o;
`endif

  modport slave (
`ifdef CC_LINE_SER_RID_EN
    input  line_id_i,
    output rid_o,
`endif
    input  line_valid_i, line_data_i, line_offset_i, rready_i,
    output line_ready_o, rdata_o, rresp_o, rlast_o, rvalid_o
  );

  modport master (
`ifdef CC_LINE_SER_RID_EN
    output line_id_i,
    input  rid_o,
`endif
    output line_valid_i, line_data_i, line_offset_i, rready_i,
    input  line_ready_o, rdata_o, rresp_o, rlast_o, rvalid_o
  );

endinterface

// File: rtl/cc_word_mux.sv
// Selects one 64-bit word out of a 512-bit cache line.
module cc_word_mux
  import cc_pkg::*;
(
  input  logic [LINE_W-1:0]   line_i,
  input  logic [OFFSET_W-1:0] idx_i,
  output logic [BEAT_W-1:0]   word_o
);

  // Word w occupies bits [64w+63:64w].
  always_comb begin
    word_o = line_i[32'(idx_i) * BEAT_W +: BEAT_W];
  end

endmodule

// File: rtl/cc_line_serializer.sv
// Returns a captured cache line as an 8-beat AXI R burst, critical word first.
// Optional R-channel ID via CC_LINE_SER_RID_EN.
module cc_line_serializer
  import cc_pkg::*;
#(
  parameter int ID_W = 4
) (
  input logic                 clk,
  input logic                 rst_n,
  cc_line_serializer_if.slave bus
);

  localparam logic [OFFSET_W-1:0] LAST_CNT = OFFSET_W'(BEATS - 1);

  state_t              state_q, state_d;
  logic [OFFSET_W-1:0] cnt_q, cnt_d;
  logic [LINE_W-1:0]   line_q, line_d;
  logic [OFFSET_W-1:0] off_q, off_d;
  logic                rvalid_q, rvalid_d;
  logic                rlast_q, rlast_d;
  logic [BEAT_W-1:0]   rdata_q, rdata_d;
  logic [BEAT_W-1:0]   word_s;
  logic [OFFSET_W-1:0] beat_idx_s;
  logic                line_hs_s;
  logic                beat_hs_s;

  // A new line is accepted while idle, or in the cycle the final beat leaves.
  assign bus.line_ready_o = (state_q == IDLE) | (rlast_q & bus.rready_i);
  assign line_hs_s        = bus.line_valid_i & bus.line_ready_o;
  assign beat_hs_s        = rvalid_q & bus.rready_i;

  assign bus.rvalid_o = rvalid_q;
  assign bus.rlast_o  = rlast_q;
  assign bus.rdata_o  = rdata_q;
  assign bus.rresp_o  = AXI_RESP_OKAY;

  // Next-state, beat counter and line capture.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    line_d  = line_q;
    off_d   = off_q;
    if (line_hs_s) begin
      state_d = SEND;
      cnt_d   = {OFFSET_W{1'b0}};
      line_d  = bus.line_data_i;
      off_d   = bus.line_offset_i;
    end else if (beat_hs_s) begin
      if (cnt_q == LAST_CNT) begin
        state_d = IDLE;
        cnt_d   = {OFFSET_W{1'b0}};
      end else begin
        cnt_d = cnt_q + 3'd1;
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  assign beat_idx_s = beat_index(off_d, cnt_d);

  cc_word_mux u_word_mux (
    .line_i (line_d),
    .idx_i  (beat_idx_s),
    .word_o (word_s)
  );

  // Outputs are computed from next state so they are valid straight from flops.
  always_comb begin
    if (state_d == SEND) begin
      rvalid_d = 1'b1;
      rlast_d  = (cnt_d == LAST_CNT);
      rdata_d  = word_s;
    end else begin
      rvalid_d = 1'b0;
      rlast_d  = 1'b0;
      rdata_d  = {BEAT_W{1'b0}};
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= {OFFSET_W{1'b0}};
      line_q   <= {LINE_W{1'b0}};
      off_q    <= {OFFSET_W{1'b0}};
      rvalid_q <= 1'b0;
      rlast_q  <= 1'b0;
      rdata_q  <= {BEAT_W{1'b0}};
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      line_q   <= line_d;
      off_q    <= off_d;
      rvalid_q <= rvalid_d;
      rlast_q  <= rlast_d;
      rdata_q  <= rdata_d;
    end
  end

`ifdef CC_LINE_SER_RID_EN
  logic [ID_W-1:0] id_q, id_d;
  logic [ID_W-1:0] rid_q, rid_d;

  assign bus.rid_o = rid_q;

  // ID capture and the ID presented with each beat.
  always_comb begin
    if (line_hs_s) begin
      id_d = bus.line_id_i;
    end else begin
      id_d = id_q;
    end
    if (state_d == SEND) begin
      rid_d = id_d;
    end else begin
      rid_d = {ID_W{1'b0}};
    end
  end

  // ID registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      id_q  <= {ID_W{1'b0}};
      rid_q <= {ID_W{1'b0}};
    end else begin
      id_q  <= id_d;
      rid_q <= rid_d;
    end
  end
`endif

endmodule

// File: tb/tb_cc_line_serializer.sv
// Scoreboard bench for cc_line_serializer: expected beats are queued when a line is presented.
module tb_cc_line_serializer;
  import cc_pkg::*;

  localparam int ID_W = 4;

  typedef struct packed {
    logic [63:0]     data;
    logic            last;
    logic [ID_W-1:0] id;
  } beat_t;

  logic  clk = 1'b0;
  logic  rst_n = 1'b0;
  beat_t sb[$];
  int    total = 0;
  int    bad = 0;

  always #5 clk = ~clk;

  cc_line_serializer_if #(.ID_W(ID_W)) bus ();

  cc_line_serializer #(.ID_W(ID_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  function automatic logic [511:0] make_line(input logic [63:0] base);
    logic [511:0] l;
    for (int w = 0; w < 8; w++) l[w*64 +: 64] = base + 64'(w);
    return l;
  endfunction

  task automatic push_line(input logic [63:0] base, input logic [2:0] off, input logic [ID_W-1:0] id);
    beat_t      e;
    logic [2:0] idx;
    for (int b = 0; b < 8; b++) begin
      idx    = off + 3'(b);
      e.data = base + 64'(idx);
      e.last = (b == 7);
      e.id   = id;
      sb.push_back(e);
    end
  endtask

  task automatic present(input logic [63:0] base, input logic [2:0] off, input logic [ID_W-1:0] id);
    bus.line_data_i   = make_line(base);
    bus.line_offset_i = off;
`ifdef CC_LINE_SER_RID_EN
    bus.line_id_i     = id;
`else
    if (id != id) $display("unreachable");
`endif
    bus.line_valid_i  = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.line_valid_i = 1'b0;
    bus.rready_i = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (bus.rvalid_o !== 1'b0) begin bad++; $display("FAIL reset_rvalid: got %b want 0", bus.rvalid_o); end
    total++; if (bus.rlast_o !== 1'b0) begin bad++; $display("FAIL reset_rlast: got %b want 0", bus.rlast_o); end
    total++; if (bus.rdata_o !== 64'd0) begin bad++; $display("FAIL reset_rdata: got %h want 0", bus.rdata_o); end
    total++; if (bus.rresp_o !== 2'b00) begin bad++; $display("FAIL reset_rresp: got %b want 00", bus.rresp_o); end
`ifdef CC_LINE_SER_RID_EN
    total++; if (bus.rid_o !== 4'h0) begin bad++; $display("FAIL reset_rid: got %h want 0", bus.rid_o); end
`endif
    rst_n = 1'b1;
    #1;
    total++; if (bus.line_ready_o !== 1'b1) begin bad++; $display("FAIL reset_line_ready: got %b want 1", bus.line_ready_o); end
  endtask

  task automatic test_critical_word(input logic [2:0] off);
    beat_t e;
    int    beats = 0;
    push_line(64'h1000, off, 4'h5);
    present(64'h1000, off, 4'h5);
    bus.rready_i = 1'b1;
    @(negedge clk);
    bus.line_valid_i = 1'b0;
    total++; if (bus.rvalid_o !== 1'b1) begin bad++; $display("FAIL cw_first_latency off=%0d: rvalid got %b want 1", off, bus.rvalid_o); end
    for (int c = 0; c < 20 && sb.size() > 0; c++) begin
      if (bus.rvalid_o === 1'b1) begin
        e = sb.pop_front();
        beats++;
        total++; if (bus.rdata_o !== e.data) begin bad++; $display("FAIL cw_data off=%0d beat=%0d: got %h want %h", off, beats, bus.rdata_o, e.data); end
        total++; if (bus.rlast_o !== e.last) begin bad++; $display("FAIL cw_last off=%0d beat=%0d: got %b want %b", off, beats, bus.rlast_o, e.last); end
        total++; if (bus.rresp_o !== 2'b00) begin bad++; $display("FAIL cw_resp: got %b want 00", bus.rresp_o); end
      end else begin
        total++; bad++; $display("FAIL cw_gap off=%0d: rvalid got %b want 1", off, bus.rvalid_o);
      end
      @(negedge clk);
    end
    total++; if (beats != 8) begin bad++; $display("FAIL cw_count off=%0d: got %0d want 8", off, beats); end
    total++; if (bus.rvalid_o !== 1'b0 || bus.rdata_o !== 64'd0) begin bad++; $display("FAIL cw_idle_after off=%0d: rvalid %b rdata %h want 0 0", off, bus.rvalid_o, bus.rdata_o); end
    sb.delete();
  endtask

  task automatic test_backpressure();
    beat_t e;
    int    beats = 0;
    int    stall = 0;
    push_line(64'h1000, 3'd0, 4'h1);
    present(64'h1000, 3'd0, 4'h1);
    bus.rready_i = 1'b1;
    @(negedge clk);
    bus.line_valid_i = 1'b0;
    for (int c = 0; c < 30 && sb.size() > 0; c++) begin
      if (bus.rvalid_o === 1'b1) begin
        e = sb[0];
        total++; if (bus.rdata_o !== e.data) begin bad++; $display("FAIL bp_data beat=%0d stall=%0d: got %h want %h", beats, stall, bus.rdata_o, e.data); end
        total++; if (bus.rlast_o !== e.last) begin bad++; $display("FAIL bp_last beat=%0d: got %b want %b", beats, bus.rlast_o, e.last); end
        if (beats == 2 && stall < 3) begin
          bus.rready_i = 1'b0;
          stall++;
        end else begin
          bus.rready_i = 1'b1;
          void'(sb.pop_front());
          beats++;
        end
      end else begin
        total++; bad++; $display("FAIL bp_gap: rvalid got %b want 1", bus.rvalid_o);
      end
      @(negedge clk);
    end
    bus.rready_i = 1'b1;
    total++; if (beats != 8) begin bad++; $display("FAIL bp_count: got %0d want 8", beats); end
    total++; if (bus.rvalid_o !== 1'b0) begin bad++; $display("FAIL bp_extra_beat: rvalid got %b want 0", bus.rvalid_o); end
    sb.delete();
  endtask

  task automatic test_back_to_back();
    beat_t e;
    logic  exp_ready;
    push_line(64'h1000, 3'd0, 4'h3);
    push_line(64'h2000, 3'd3, 4'hA);
    present(64'h1000, 3'd0, 4'h3);
    bus.rready_i = 1'b1;
    @(negedge clk);
    present(64'h2000, 3'd3, 4'hA);
    for (int i = 0; i < 16; i++) begin
      #1;
      exp_ready = (i == 7) || (i == 15);
      total++; if (bus.line_ready_o !== exp_ready) begin bad++; $display("FAIL b2b_line_ready cycle=%0d: got %b want %b", i, bus.line_ready_o, exp_ready); end
      total++; if (bus.rvalid_o !== 1'b1) begin bad++; $display("FAIL b2b_gap cycle=%0d: rvalid got %b want 1", i, bus.rvalid_o); end
      e = sb.pop_front();
      total++; if (bus.rdata_o !== e.data) begin bad++; $display("FAIL b2b_data cycle=%0d: got %h want %h", i, bus.rdata_o, e.data); end
      total++; if (bus.rlast_o !== e.last) begin bad++; $display("FAIL b2b_last cycle=%0d: got %b want %b", i, bus.rlast_o, e.last); end
`ifdef CC_LINE_SER_RID_EN
      total++; if (bus.rid_o !== e.id) begin bad++; $display("FAIL b2b_rid cycle=%0d: got %h want %h", i, bus.rid_o, e.id); end
`endif
      if (i == 8) bus.line_valid_i = 1'b0;
      @(negedge clk);
    end
    total++; if (bus.rvalid_o !== 1'b0) begin bad++; $display("FAIL b2b_idle_after: rvalid got %b want 0", bus.rvalid_o); end
    sb.delete();
  endtask

  task automatic test_reset_mid_burst();
    beat_t e;
    int    late = 0;
    push_line(64'h1000, 3'd0, 4'h7);
    present(64'h1000, 3'd0, 4'h7);
    bus.rready_i = 1'b1;
    @(negedge clk);
    bus.line_valid_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      e = sb.pop_front();
      total++; if (bus.rdata_o !== e.data) begin bad++; $display("FAIL rst_mid_data beat=%0d: got %h want %h", i, bus.rdata_o, e.data); end
      if (i < 3) @(negedge clk);
    end
    rst_n = 1'b0;
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    total++; if (bus.rvalid_o !== 1'b0 || bus.rlast_o !== 1'b0 || bus.rdata_o !== 64'd0) begin
      bad++; $display("FAIL rst_mid_outputs: rvalid %b rlast %b rdata %h want 0 0 0", bus.rvalid_o, bus.rlast_o, bus.rdata_o);
    end
    total++; if (bus.line_ready_o !== 1'b1) begin bad++; $display("FAIL rst_mid_line_ready: got %b want 1", bus.line_ready_o); end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.rvalid_o !== 1'b0) late++;
    end
    total++; if (late != 0) begin bad++; $display("FAIL rst_mid_no_resume: got %0d beats want 0", late); end
  endtask

  initial begin
    bus.line_valid_i  = 1'b0;
    bus.line_data_i   = 512'd0;
    bus.line_offset_i = 3'd0;
    bus.rready_i      = 1'b0;
`ifdef CC_LINE_SER_RID_EN
    bus.line_id_i     = 4'h0;
`endif
    test_reset();
    test_critical_word(3'd0);
    test_critical_word(3'd5);
    test_backpressure();
    test_back_to_back();
    test_reset_mid_burst();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
